mc_control: RTL
===============

# mc_control

Multi-cycle MIPS main controller. A Moore-style FSM sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer side of the `aluop` interface: the ALU decoder consumes `aluop` plus `funct` and emits the 3-bit ALU control. It also drives every datapath mux select and write strobe, and stalls on a single-port memory through a `mem_req`/`mem_ready` handshake.

## Interface
- no parameters; opcode width fixed at 6
- `clk` in 1: single clock; all state changes on the rising edge
- `rst_n` in 1: asynchronous assert, active-low; state forced to FETCH while low
- `opcode` in 6: instruction register bits [31:26], stable from DECODE onward
- `zero` in 1: ALU zero flag, valid in BEQEX
- `mem_ready` in 1: memory completes the current access this cycle
- `mem_req` out 1: memory access in progress
- `memwrite` out 1: store strobe
- `irwrite` out 1: instruction register load
- `regwrite` out 1: register file write
- `pcen` out 1: PC load enable, equal to `pcwrite | (branch & zero)`
- `iord` out 1: memory address from ALUOut (1) or PC (0)
- `memtoreg` out 1: writeback data from Data register (1) or ALUOut (0)
- `regdst` out 1: destination register from rd (1) or rt (0)
- `alusrca` out 1: ALU A input from register A (1) or PC (0)
- `alusrcb` out 2: ALU B input; 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- `pcsrc` out 2: next PC; 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `aluop` out 2: 00 = add, 01 = sub, 10 = use `funct`
- `illegal` out 1: unrecognised opcode seen in DECODE
- `state` out 4: current state encoding, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 return to FETCH on the next edge; all outputs are 0 in those codes.
- Every output not listed for a state is 0.
- FETCH: `mem_req`=1, `alusrcb`=01.
  - `irwrite` and `pcwrite` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- DECODE: `alusrcb`=11. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - any other opcode → FETCH with `illegal`=1 for that one cycle
- MEMADR: `alusrca`=1, `alusrcb`=10. Go to MEMRD for lw, MEMWR for sw (opcode re-checked).
- MEMRD: `mem_req`=1, `iord`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1. Go to FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1; all three held until `mem_ready`. Then go to FETCH.
- RTYPEEX: `alusrca`=1, `aluop`=10. Go to RTYPEWB.
- RTYPEWB: `regdst`=1, `regwrite`=1. Go to FETCH.
- BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1 (internal). Go to FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10. Go to ADDIWB.
- ADDIWB: `regwrite`=1. Go to FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1. Go to FETCH.

## Timing
- Reset:
  - `rst_n` low asynchronously sets `state`=0 (FETCH).
  - While low, `mem_req`, `irwrite`, `pcen`, `regwrite`, `memwrite` and `illegal` are forced to 0.
  - Mux selects show their FETCH values; `alusrcb`=01, all others 0.
- Reset deassertion: synchronised; the first FETCH access starts on the first edge after release.
- Reset asserted mid-instruction, including during a pending memory access, abandons it with no further strobes.
- Cycles per instruction with `mem_ready` tied to 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
  - Each wait cycle on `mem_ready` adds 1.
- Outputs are combinational from `state`; only `irwrite`, `pcen` and `memwrite` completion depend on same-cycle `mem_ready` and `zero`. There is no registered output latency.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- `zero` outside BEQEX does not affect `pcen`.

## Test plan
- Reset: hold `rst_n`=0 with `mem_ready`=1 → `state`=0, `pcen`=0, `irwrite`=0, `mem_req`=0. Release → next cycle `mem_req`=1, `irwrite`=1, `pcen`=1.
- lw with `mem_ready`=1: opcode 100011 → states 0,1,2,3,4,0. `aluop`=00 throughout. `regwrite`=1 and `memtoreg`=1 only in state 4.
- R-type then beq:
  - 000000 → `aluop`=10 in state 6, `regdst`=1 and `regwrite`=1 in state 7.
  - 000100 with `zero`=1 → `aluop`=01, `pcsrc`=01, `pcen`=1 in state 8.
  - Repeat beq with `zero`=0 → `pcen`=0.
- sw with stalls: opcode 101011, `mem_ready` low for 3 cycles in MEMWR → `memwrite`=1 and `iord`=1 for 4 cycles, then FETCH. Total 7 cycles.
- Illegal and jump:
  - Opcode 111111 → `illegal`=1 for one cycle in DECODE, then FETCH, with no write strobes.
  - 000010 → `pcsrc`=10, `pcen`=1 in state 11.
- Reset mid-access: assert `rst_n`=0 in MEMRD with `mem_ready`=0 → `state`=0 and `mem_req`=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS main controller: Moore FSM driving datapath selects/strobes.
// Ports: clk, rst_n, opcode/zero/mem_ready in; mem_req..aluop, illegal, state out.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_run;

  logic w_lw, w_sw, w_rt, w_beq, w_addi, w_j;
  logic w_mem_req, w_memwrite, w_irwrite, w_regwrite;
  logic w_pcwrite, w_branch, w_illegal;

  assign w_lw   = (opcode == 6'b100011);
  assign w_sw   = (opcode == 6'b101011);
  assign w_rt   = (opcode == 6'b000000);
  assign w_beq  = (opcode == 6'b000100);
  assign w_addi = (opcode == 6'b001000);
  assign w_j    = (opcode == 6'b000010);

  // r_run delays the first FETCH access to the first edge after release,
  // so reset deassertion is seen synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_mem_req  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        alusrcb   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (1'b1)
          w_lw, w_sw: w_next = S_MEMADR;
          w_rt:       w_next = S_RTYPEEX;
          w_beq:      w_next = S_BEQEX;
          w_addi:     w_next = S_ADDIEX;
          w_j:        w_next = S_JEX;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        unique case (1'b1)
          w_lw:    w_next = S_MEMRD;
          w_sw:    w_next = S_MEMWR;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        w_next    = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_memwrite = 1'b1;
        iord       = 1'b1;
        w_next     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are suppressed until the first edge after reset release.
  assign mem_req  = w_mem_req & r_run;
  assign memwrite = w_memwrite & r_run;
  assign irwrite  = w_irwrite & r_run;
  assign regwrite = w_regwrite & r_run;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & r_run;
  assign illegal  = w_illegal & r_run;
  assign state    = r_state;

endmodule
